// File: rtl/cond_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_unit_pkg
// Brief    : Condition-code and FSM state encodings for the branch resolver.
// Revision : 1.0
// ============================================================================
package cond_branch_unit_pkg;

    typedef logic [3:0] cond_t;

    localparam cond_t c_COND_EQ = 4'h0;
    localparam cond_t c_COND_NE = 4'h1;
    localparam cond_t c_COND_CS = 4'h2;
    localparam cond_t c_COND_CC = 4'h3;
    localparam cond_t c_COND_MI = 4'h4;
    localparam cond_t c_COND_PL = 4'h5;
    localparam cond_t c_COND_VS = 4'h6;
    localparam cond_t c_COND_VC = 4'h7;
    localparam cond_t c_COND_HI = 4'h8;
    localparam cond_t c_COND_LS = 4'h9;
    localparam cond_t c_COND_GE = 4'hA;
    localparam cond_t c_COND_LT = 4'hB;
    localparam cond_t c_COND_GT = 4'hC;
    localparam cond_t c_COND_LE = 4'hD;
    localparam cond_t c_COND_AL = 4'hE;
    localparam cond_t c_COND_NV = 4'hF;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_WAIT = 2'd1;
    localparam state_t c_ST_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cond_branch_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Brief    : Combinational condition-code evaluator over the C/V/N/Z flags.
// Revision : 1.0
// ============================================================================
module cond_eval
    import cond_branch_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       carry_flag,
    input  logic       overflow_flag,
    input  logic       negative_flag,
    input  logic       zero_flag,
    output logic       taken
);

    logic w_n_eq_v;

    assign w_n_eq_v = (negative_flag == overflow_flag);

    always_comb begin
        taken = 1'b0;
        case (cond)
            c_COND_EQ: taken = zero_flag;
            c_COND_NE: taken = ~zero_flag;
            c_COND_CS: taken = carry_flag;
            c_COND_CC: taken = ~carry_flag;
            c_COND_MI: taken = negative_flag;
            c_COND_PL: taken = ~negative_flag;
            c_COND_VS: taken = overflow_flag;
            c_COND_VC: taken = ~overflow_flag;
            c_COND_HI: taken = carry_flag & ~zero_flag;
            c_COND_LS: taken = ~carry_flag | zero_flag;
            c_COND_GE: taken = w_n_eq_v;
            c_COND_LT: taken = ~w_n_eq_v;
            c_COND_GT: taken = ~zero_flag & w_n_eq_v;
            c_COND_LE: taken = zero_flag | ~w_n_eq_v;
            c_COND_AL: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cond_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_unit
// Brief    : Resolves conditional branches against the ALU flags once any
//            in-flight flag write has landed; counts taken branches.
// Revision : 1.0
// ============================================================================
module cond_branch_unit
    import cond_branch_unit_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cond,
    input  logic [PC_W-1:0]  req_pc,
    input  logic [PC_W-1:0]  req_offset,
    input  logic             carry_flag,
    input  logic             overflow_flag,
    input  logic             negative_flag,
    input  logic             zero_flag,
    input  logic             flag_write_pending,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic [PC_W-1:0]  resp_next_pc,
    output logic [CNT_W-1:0] taken_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cond;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_offset;
    logic              r_resp_taken;
    logic [PC_W-1:0]   r_resp_next_pc;
    logic [CNT_W-1:0]  r_taken_count;
    logic              w_accept;
    logic              w_eval;
    logic              w_taken;

    assign w_accept = (r_state == c_ST_IDLE) & req_valid;
    // Flags are only trusted once no write is landing on this edge.
    assign w_eval   = (r_state == c_ST_WAIT) & ~flag_write_pending;

    cond_eval u_cond_eval (
        .cond          (r_cond),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .negative_flag (negative_flag),
        .zero_flag     (zero_flag),
        .taken         (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (req_valid)           w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (!flag_write_pending) w_state_nxt = c_ST_RESP;
            c_ST_RESP: if (resp_ready)          w_state_nxt = c_ST_IDLE;
            default:                            w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cond         <= '0;
            r_pc           <= '0;
            r_offset       <= '0;
            r_resp_taken   <= 1'b0;
            r_resp_next_pc <= '0;
            r_taken_count  <= '0;
        end else begin
            if (w_accept) begin
                r_cond   <= req_cond;
                r_pc     <= req_pc;
                r_offset <= req_offset;
            end
            if (w_eval) begin
                r_resp_taken   <= w_taken;
                r_resp_next_pc <= w_taken ? (r_pc + r_offset) : (r_pc + PC_W'(1));
                if (w_taken && !(&r_taken_count)) begin
                    r_taken_count <= r_taken_count + CNT_W'(1);
                end
            end
        end
    end

    assign req_ready    = (r_state == c_ST_IDLE);
    assign resp_valid   = (r_state == c_ST_RESP);
    assign resp_taken   = r_resp_taken;
    assign resp_next_pc = r_resp_next_pc;
    assign taken_count  = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_cond_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_branch_unit
// Brief    : Directed scoreboard bench for cond_branch_unit (16-bit and 4-bit
//            counter builds driven in lockstep).
// Revision : 1.0
// ============================================================================
module tb_cond_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_cond;
    logic [15:0] req_pc;
    logic [15:0] req_offset;
    logic        carry_flag, overflow_flag, negative_flag, zero_flag;
    logic        flag_write_pending;
    logic        resp_ready;

    wire         req_ready, resp_valid, resp_taken;
    wire  [15:0] resp_next_pc;
    wire  [15:0] taken_count;
    wire         s_req_ready, s_resp_valid, s_resp_taken;
    wire  [15:0] s_resp_next_pc;
    wire  [3:0]  s_taken_count;

    always #5 clk = ~clk;

    cond_branch_unit #(.PC_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
        .req_pc(req_pc), .req_offset(req_offset),
        .carry_flag(carry_flag), .overflow_flag(overflow_flag),
        .negative_flag(negative_flag), .zero_flag(zero_flag),
        .flag_write_pending(flag_write_pending),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_taken(resp_taken), .resp_next_pc(resp_next_pc),
        .taken_count(taken_count)
    );

    cond_branch_unit #(.PC_W(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_cond(req_cond),
        .req_pc(req_pc), .req_offset(req_offset),
        .carry_flag(carry_flag), .overflow_flag(overflow_flag),
        .negative_flag(negative_flag), .zero_flag(zero_flag),
        .flag_write_pending(flag_write_pending),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready),
        .resp_taken(s_resp_taken), .resp_next_pc(s_resp_next_pc),
        .taken_count(s_taken_count)
    );

    typedef struct packed {
        logic        taken;
        logic [15:0] next_pc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   model_cnt  = 0;
    int   model_cnt4 = 0;

    function automatic logic model_taken(input logic [3:0] cc, input logic [3:0] f);
        logic c, v, n, z;
        {c, v, n, z} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_flags(input logic [3:0] f);
        {carry_flag, overflow_flag, negative_flag, zero_flag} = f;
    endtask

    // One full branch: accept, optional pending cycles, optional response stall.
    task automatic branch(input logic [3:0] cc, input logic [15:0] pc, input logic [15:0] off,
                          input logic [3:0] f_new, input logic [3:0] f_old,
                          input int pend, input int hold);
        exp_t e;
        exp_t got;
        req_valid = 1'b1; req_cond = cc; req_pc = pc; req_offset = off;
        set_flags(pend > 0 ? f_old : f_new);
        flag_write_pending = (pend > 0);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_cond = ~cc; req_pc = 16'hDEAD; req_offset = 16'h1234;
        e.taken   = model_taken(cc, f_new);
        e.next_pc = e.taken ? 16'(pc + off) : 16'(pc + 16'd1);
        sb.push_back(e);
        if (e.taken) begin
            if (model_cnt < 65535) model_cnt++;
            if (model_cnt4 < 15) model_cnt4++;
        end
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < pend; i++) begin
            chk("resp_valid_pending", {31'd0, resp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        set_flags(f_new);
        flag_write_pending = 1'b0;
        chk("resp_valid_wait", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("resp_valid_latency", {31'd0, resp_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_empty: observed=empty expected=entry");
        end else begin
            got = sb.pop_front();
            chk("resp_taken", {31'd0, resp_taken}, {31'd0, got.taken});
            chk("resp_next_pc", {16'd0, resp_next_pc}, {16'd0, got.next_pc});
            chk("taken_count", {16'd0, taken_count}, model_cnt);
            chk("taken_count_w4", {28'd0, s_taken_count}, model_cnt4);
            resp_ready = (hold == 0);
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'b1; req_cond = 4'hE; req_pc = 16'h5555;
                set_flags(~f_new);
                @(posedge clk); #1;
                chk("hold_valid", {31'd0, resp_valid}, 32'd1);
                chk("hold_taken", {31'd0, resp_taken}, {31'd0, got.taken});
                chk("hold_next_pc", {16'd0, resp_next_pc}, {16'd0, got.next_pc});
                chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
            req_valid = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            chk("post_valid", {31'd0, resp_valid}, 32'd0);
            chk("post_req_ready", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_cond = 4'h0; req_pc = '0; req_offset = '0;
        set_flags(4'h0); flag_write_pending = 1'b0; resp_ready = 1'b0;
        #3;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_taken", {31'd0, resp_taken}, 32'd0);
        chk("rst_next_pc", {16'd0, resp_next_pc}, 32'd0);
        chk("rst_count", {16'd0, taken_count}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // flags packed as {C, V, N, Z}
        branch(4'h0, 16'h0010, 16'h0005, 4'b0001, 4'b0000, 0, 0);
        branch(4'hB, 16'h0100, 16'hFFF0, 4'b0010, 4'b0000, 0, 0);
        branch(4'hB, 16'h0100, 16'hFFF0, 4'b0110, 4'b0000, 0, 0);
        branch(4'h0, 16'h0200, 16'h0020, 4'b0001, 4'b0000, 3, 0);
        branch(4'hC, 16'h0300, 16'h0007, 4'b0000, 4'b0000, 0, 4);
        branch(4'hF, 16'hFFFF, 16'h0010, 4'b1111, 4'b0000, 0, 0);
        branch(4'hE, 16'hFFFE, 16'h0003, 4'b0000, 4'b0000, 0, 0);
        for (int c = 0; c < 16; c++) begin
            branch(4'(c), 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), c % 3, c % 2);
        end

        // Reset while a request sits in WAIT behind a pending flag write.
        req_valid = 1'b1; req_cond = 4'hE; req_pc = 16'h0400; req_offset = 16'h0004;
        flag_write_pending = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_count", {16'd0, taken_count}, 32'd0);
        chk("midrst_taken", {31'd0, resp_taken}, 32'd0);
        flag_write_pending = 1'b0;
        model_cnt = 0; model_cnt4 = 0;
        @(posedge clk); #1;
        chk("midrst_hold_valid", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            branch(4'hE, 16'(i), 16'h0001, 4'b0000, 4'b0000, 0, 0);
        end
        chk("sat_count_w4", {28'd0, s_taken_count}, 32'd15);
        chk("count_w16", {16'd0, taken_count}, 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
